// File: rtl/morse_pkg.sv
// Shared Morse symbol codes, sequence widths and the stored-entry layout.
// Pure definitions: no logic, no latency.
// No flow control.
package morse_pkg;

    localparam logic [1:0] SYM_DOT   = 2'b00;
    localparam logic [1:0] SYM_DASH  = 2'b01;
    localparam logic [1:0] SYM_SEP   = 2'b10;
    localparam logic [1:0] SYM_EMPTY = 2'b11;

    localparam int SYMS_PER_SEQ = 5;
    localparam int SEQ_W        = 2 * SYMS_PER_SEQ;
    localparam int ENTRY_W      = 2 * SEQ_W;

    localparam logic [SEQ_W-1:0] EMPTY_SEQ = {SYMS_PER_SEQ{SYM_EMPTY}};

    // seq_a is declared first so it lands in the upper half of a packed entry
    typedef struct packed {
        logic [SEQ_W-1:0] seq_a;
        logic [SEQ_W-1:0] seq_b;
    } entry_t;

    localparam entry_t EMPTY_ENTRY = '{seq_a: EMPTY_SEQ, seq_b: EMPTY_SEQ};

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: pulses for the cycle in which din is first sampled high.
// Latency: pulse is combinational from din against one registered copy.
// No flow control; delayed copy resets to 1 so a level held through reset never pulses.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_q <= 1'b1;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/morse_sequence_storage.sv
// Stores up to NUM_SLOTS committed {first_seq, sec_seq} entries, oldest in the MSBs.
// Latency: a commit on the enter rising edge is visible on o_sequence right after that edge.
// No backpressure: when full, the oldest entry is dropped to make room.
module morse_sequence_storage
    import morse_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enter,
    input  logic [SEQ_W-1:0]             first_seq,
    input  logic [SEQ_W-1:0]             sec_seq,
    output logic [ENTRY_W*NUM_SLOTS-1:0] o_sequence
);

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    entry_t           slots     [NUM_SLOTS];
    entry_t           slots_nxt [NUM_SLOTS];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             commit;
    logic             blank;
    entry_t           new_entry;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .din   (enter),
        .rise  (commit)
    );

    assign new_entry = '{seq_a: first_seq, seq_b: sec_seq};
    assign blank     = (first_seq == EMPTY_SEQ) && (sec_seq == EMPTY_SEQ);

    always_comb begin
        slots_nxt = slots;
        cnt_nxt   = cnt;
        if (commit && !blank) begin
            if (cnt == CNT_W'(NUM_SLOTS)) begin
                // Full: slide everything one slot toward the oldest end
                for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                    slots_nxt[i] = slots[i+1];
                end
                slots_nxt[NUM_SLOTS-1] = new_entry;
            end else begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        slots_nxt[i] = new_entry;
                    end
                end
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= EMPTY_ENTRY;
            end
            cnt <= '0;
        end else begin
            slots <= slots_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        o_sequence = '1;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            o_sequence[ENTRY_W*(NUM_SLOTS-1-k) +: ENTRY_W] = slots[k];
        end
    end

endmodule

// File: tb/tb_morse_sequence_storage.sv
// Directed bench: stimulus queues the expected o_sequence value and cycle for each change;
// a negedge monitor pops and compares whenever o_sequence moves.
module tb_morse_sequence_storage;

    typedef struct {
        logic [159:0] val;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         enter;
    logic [9:0]   first_seq;
    logic [9:0]   sec_seq;
    logic [159:0] o_sequence;

    exp_t         q[$];
    int           compared;
    int           mismatched;
    int           cyc_cnt;
    logic [159:0] prev;
    logic [19:0]  ent [10];
    logic [159:0] exp_v;

    morse_sequence_storage #(.NUM_SLOTS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enter      (enter),
        .first_seq  (first_seq),
        .sec_seq    (sec_seq),
        .o_sequence (o_sequence)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt = cyc_cnt + 1;

    // Monitor: any movement of o_sequence must match the oldest queued expectation
    initial prev = 'x;
    always @(negedge clk) begin
        exp_t e;
        if (o_sequence !== prev) begin
            prev = o_sequence;
            compared = compared + 1;
            if (q.size() == 0) begin
                mismatched = mismatched + 1;
                $display("FAIL unexpected_change cyc=%0d got=%h", cyc_cnt, o_sequence);
            end else begin
                e = q.pop_front();
                if (e.val !== o_sequence || (e.cyc >= 0 && e.cyc != cyc_cnt)) begin
                    mismatched = mismatched + 1;
                    $display("FAIL seq_update got=%h at cyc %0d, want=%h at cyc %0d",
                             o_sequence, cyc_cnt, e.val, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
        compared = compared + 1;
        if (got !== want) begin
            mismatched = mismatched + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Raise enter with the given data for 'hold' edges, then drop it for one edge
    task automatic commit(input logic [9:0] a, input logic [9:0] b, input int hold,
                          input bit exp_change, input logic [159:0] exp_val);
        @(negedge clk);
        first_seq = a;
        sec_seq   = b;
        enter     = 1'b1;
        if (exp_change) q.push_back('{exp_val, cyc_cnt + 1});
        repeat (hold) @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        q.push_back('{'1, cyc_cnt});
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        ent[0] = 20'h00000; ent[1] = 20'h11111; ent[2] = 20'h22222; ent[3] = 20'h33333;
        ent[4] = 20'h44444; ent[5] = 20'h55555; ent[6] = 20'h66666; ent[7] = 20'h77777;
        ent[8] = 20'h88888; ent[9] = 20'h99999;

        reset     = 1'b1;
        enter     = 1'b0;
        first_seq = 10'h3FF;
        sec_seq   = 10'h3FF;
        q.push_back('{'1, -1});
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_out", o_sequence, '1);
        check("rst_cnt", 160'(dut.cnt), 160'd0);

        // Held enter commits exactly once
        commit(10'b0100111111, 10'h3FF, 3, 1'b1, {20'b0100111111_1111111111, {140{1'b1}}});

        // Entry changes with enter low must not disturb the buffer
        @(negedge clk);
        first_seq = 10'b0001000100;
        sec_seq   = 10'b1011111111;
        @(negedge clk);
        first_seq = 10'b1011111111;
        sec_seq   = 10'h3FF;
        repeat (2) @(negedge clk);
        commit(10'b1011111111, 10'h3FF, 1, 1'b1,
               {20'b0100111111_1111111111, 20'b1011111111_1111111111, {120{1'b1}}});

        // Blank entry is skipped; the next real entry takes slot 2
        commit(10'h3FF, 10'h3FF, 1, 1'b0, '0);
        commit(10'b0000011111, 10'b0101011111, 1, 1'b1,
               {20'b0100111111_1111111111, 20'b1011111111_1111111111,
                20'b0000011111_0101011111, {100{1'b1}}});

        // Reset with enter held high across release must not commit
        @(negedge clk);
        enter = 1'b1;
        first_seq = 10'b0101010101;
        sec_seq   = 10'b0000000000;
        do_reset();
        repeat (2) @(negedge clk);
        enter = 1'b0;
        @(negedge clk);

        // Fill from slot 0 after reset, then overflow twice
        exp_v = '1;
        for (int i = 0; i < 8; i++) begin
            exp_v[159-20*i -: 20] = ent[i];
            commit(ent[i][19:10], ent[i][9:0], 1, 1'b1, exp_v);
        end
        commit(ent[8][19:10], ent[8][9:0], 2, 1'b1,
               {ent[1], ent[2], ent[3], ent[4], ent[5], ent[6], ent[7], ent[8]});
        commit(ent[9][19:10], ent[9][9:0], 1, 1'b1,
               {ent[2], ent[3], ent[4], ent[5], ent[6], ent[7], ent[8], ent[9]});
        check("full_cnt", 160'(dut.cnt), 160'd8);

        // Bounded drain of outstanding expectations
        for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
        check("drain", 160'(q.size()), 160'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
